// File: rtl/spi_master_ctrl_if.sv
// CPU register-bus bundle for the SPI master control stage: address, write data, strobes and registered read data.
// The master modport is the CPU/bench side; the slave modport is the control block.
interface spi_master_ctrl_if #(
  parameter int DATA_WIDTH = 32
);
  logic [1:0]            bus_addr;
  logic [DATA_WIDTH-1:0] bus_wdata;
  logic                  bus_we;
  logic                  bus_re;
  logic [DATA_WIDTH-1:0] bus_rdata;

  modport master (
    output bus_addr,
    output bus_wdata,
    output bus_we,
    output bus_re,
    input  bus_rdata
  );

  modport slave (
    input  bus_addr,
    input  bus_wdata,
    input  bus_we,
    input  bus_re,
    output bus_rdata
  );
endinterface

// File: rtl/spi_master_ctrl.sv
// SPI master control stage: CTRL/TXDATA/RXDATA/STATUS registers and the per-transfer CS/shifter sequencer.
// Optional SHIFT-state abort counter is enabled by defining SPI_TIMEOUT_EN.
module spi_master_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int CS_SETUP   = 2,
  parameter int CS_HOLD    = 2,
  parameter int TIMEOUT    = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  spi_master_ctrl_if.slave      bus,
  output logic                  irq,
  output logic                  CS_n,
  output logic                  shf_rst,
  output logic                  shf_load,
  output logic [DATA_WIDTH-1:0] shf_data,
  output logic [1:0]            shf_len,
  input  logic                  shf_done,
  input  logic [DATA_WIDTH-1:0] shf_rx
);

  if (CS_SETUP < 1 || CS_SETUP > 15) begin : g_bad_setup
    $error("CS_SETUP must be in 1..15");
  end
  if (CS_HOLD < 1 || CS_HOLD > 15) begin : g_bad_hold
    $error("CS_HOLD must be in 1..15");
  end
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("TIMEOUT must fit the 8-bit counter");
  end

  localparam logic [3:0] SETUP_LAST = 4'(CS_SETUP - 1);
  localparam logic [3:0] HOLD_LAST  = 4'(CS_HOLD - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RST,
    S_SETUP,
    S_SHIFT,
    S_CAPTURE,
    S_HOLD
  } state_e;

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [1:0]            len_q, len_d;
  logic                  irq_en_q, irq_en_d;
  logic [DATA_WIDTH-1:0] txdata_q, txdata_d;
  logic [DATA_WIDTH-1:0] rxdata_q, rxdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  done_q, done_d;
  logic                  ovr_q, ovr_d;
  logic                  cs_n_q, cs_n_d;
  logic                  shf_rst_q, shf_rst_d;
  logic                  shf_load_q, shf_load_d;
  logic                  tmo_flag;

`ifdef SPI_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
  logic [7:0] tmo_cnt_q, tmo_cnt_d;
  logic       tmo_q, tmo_d;
  assign tmo_flag = tmo_q;
`else
  assign tmo_flag = 1'b0;
`endif

  logic                  busy;
  logic                  wr_ctrl, wr_tx, wr_stat, start_req;
  logic [DATA_WIDTH-1:0] rx_mask, ctrl_rd, status_rd;

  assign busy      = (state_q != S_IDLE);
  assign wr_ctrl   = bus.bus_we && (bus.bus_addr == 2'd0);
  assign wr_tx     = bus.bus_we && (bus.bus_addr == 2'd1);
  assign wr_stat   = bus.bus_we && (bus.bus_addr == 2'd3);
  assign start_req = wr_ctrl && bus.bus_wdata[0];

  // Keep only the low 8*(len+1) bits of the received word.
  always_comb begin
    rx_mask = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      rx_mask[i] = (i < 8 * (int'(len_q) + 1));
    end
  end

  always_comb begin
    ctrl_rd      = '0;
    ctrl_rd[2:1] = len_q;
    ctrl_rd[3]   = irq_en_q;
    status_rd    = '0;
    status_rd[0] = busy;
    status_rd[1] = done_q;
    status_rd[2] = ovr_q;
    status_rd[3] = tmo_flag;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    irq_en_d = irq_en_q;
    txdata_d = txdata_q;
    rxdata_d = rxdata_q;
    rdata_d  = rdata_q;
    done_d   = done_q;
    ovr_d    = ovr_q;
`ifdef SPI_TIMEOUT_EN
    tmo_d     = tmo_q;
    tmo_cnt_d = (state_q == S_SHIFT) ? tmo_cnt_q + 8'd1 : 8'd0;
`endif

    // Transfer parameters are frozen while a transfer is in flight.
    if (wr_ctrl) begin
      irq_en_d = bus.bus_wdata[3];
      if (!busy) begin
        len_d = bus.bus_wdata[2:1];
      end
    end
    if (wr_tx && !busy) begin
      txdata_d = bus.bus_wdata;
    end

    // Clears are applied first so that a same-cycle set takes priority.
    if (wr_stat) begin
      if (bus.bus_wdata[1]) done_d = 1'b0;
      if (bus.bus_wdata[2]) ovr_d  = 1'b0;
`ifdef SPI_TIMEOUT_EN
      if (bus.bus_wdata[3]) tmo_d  = 1'b0;
`endif
    end
    if (start_req && busy) begin
      ovr_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (start_req) begin
          state_d = S_RST;
          cnt_d   = 4'd0;
          done_d  = 1'b0;
        end
      end
      S_RST: begin
        state_d = S_SETUP;
        cnt_d   = 4'd0;
      end
      S_SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          state_d = S_SHIFT;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_SHIFT: begin
        if (shf_done) begin
          state_d = S_CAPTURE;
`ifdef SPI_TIMEOUT_EN
        end else if (tmo_cnt_q == TMO_LAST) begin
          state_d = S_HOLD;
          cnt_d   = 4'd0;
          tmo_d   = 1'b1;
`endif
        end
      end
      S_CAPTURE: begin
        rxdata_d = shf_rx & rx_mask;
        state_d  = S_HOLD;
        cnt_d    = 4'd0;
      end
      S_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (bus.bus_re) begin
      case (bus.bus_addr)
        2'd0:    rdata_d = ctrl_rd;
        2'd1:    rdata_d = txdata_q;
        2'd2:    rdata_d = rxdata_q;
        default: rdata_d = status_rd;
      endcase
    end

    cs_n_d     = (state_d == S_IDLE);
    shf_rst_d  = (state_d == S_RST);
    shf_load_d = (state_d == S_SHIFT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      len_q      <= 2'd0;
      irq_en_q   <= 1'b0;
      txdata_q   <= '0;
      rxdata_q   <= '0;
      rdata_q    <= '0;
      done_q     <= 1'b0;
      ovr_q      <= 1'b0;
      cs_n_q     <= 1'b1;
      shf_rst_q  <= 1'b0;
      shf_load_q <= 1'b0;
`ifdef SPI_TIMEOUT_EN
      tmo_q      <= 1'b0;
      tmo_cnt_q  <= 8'd0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      irq_en_q   <= irq_en_d;
      txdata_q   <= txdata_d;
      rxdata_q   <= rxdata_d;
      rdata_q    <= rdata_d;
      done_q     <= done_d;
      ovr_q      <= ovr_d;
      cs_n_q     <= cs_n_d;
      shf_rst_q  <= shf_rst_d;
      shf_load_q <= shf_load_d;
`ifdef SPI_TIMEOUT_EN
      tmo_q      <= tmo_d;
      tmo_cnt_q  <= tmo_cnt_d;
`endif
    end
  end

  assign CS_n          = cs_n_q;
  assign shf_rst       = shf_rst_q;
  assign shf_load      = shf_load_q;
  assign shf_data      = txdata_q;
  assign shf_len       = len_q;
  assign irq           = done_q & irq_en_q;
  assign bus.bus_rdata = rdata_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: transfer vector table, register read scoreboard, and
// hand-written sequences for overrun, W1C/set collision, mid-transfer reset and timeout.
module tb_spi_master_ctrl;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          irq, cs_n, shf_rst, shf_load, shf_done;
  logic [DW-1:0] shf_data, shf_rx;
  logic [1:0]    shf_len;
  logic          model_done = 1'b0;
  logic          stray_done = 1'b0;
  logic [31:0]   rx_val = 32'h0;
  int            done_delay = 9;
  int            checks = 0;
  int            errors = 0;
  logic [31:0]   exp_q[$];
  string         name_q[$];
  logic          rd_pend = 1'b0;

  always #5 clk = ~clk;

  spi_master_ctrl_if #(.DATA_WIDTH(DW)) bus_if ();

  spi_master_ctrl #(
    .DATA_WIDTH(DW), .CS_SETUP(2), .CS_HOLD(2), .TIMEOUT(64)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus_if),
    .irq      (irq),
    .CS_n     (cs_n),
    .shf_rst  (shf_rst),
    .shf_load (shf_load),
    .shf_data (shf_data),
    .shf_len  (shf_len),
    .shf_done (shf_done),
    .shf_rx   (shf_rx)
  );

  assign shf_done = model_done | stray_done;
  assign shf_rx   = rx_val;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Read scoreboard: expectation queued at the strobe, compared one cycle later.
  always @(posedge clk) rd_pend <= bus_if.bus_re;
  always @(negedge clk) begin
    if (rd_pend) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_unexpected: got 0x%08h, expected no read data", bus_if.bus_rdata);
      end else begin
        check(name_q.pop_front(), bus_if.bus_rdata, exp_q.pop_front());
      end
    end
  end

  // Shifter model: raises done during the Nth cycle of shf_load.
  initial begin
    forever begin
      @(posedge shf_load);
      if (done_delay > 0) begin
        repeat (done_delay - 1) @(posedge clk);
        #1 model_done = 1'b1;
        @(posedge clk);
        #1 model_done = 1'b0;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    bus_if.bus_addr  = a;
    bus_if.bus_wdata = d;
    bus_if.bus_we    = 1'b1;
    @(posedge clk);
    #1 bus_if.bus_we = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, input logic [31:0] exp, input string name);
    exp_q.push_back(exp);
    name_q.push_back(name);
    bus_if.bus_addr = a;
    bus_if.bus_re   = 1'b1;
    @(posedge clk);
    #1 bus_if.bus_re = 1'b0;
  endtask

  // Follows one transfer at negedges; mode 1: STATUS W1C in last CS cycle,
  // mode 2: start + TXDATA write during SHIFT, mode 3: reset during SHIFT.
  task automatic wait_xfer(input int mode, output int low, output int loads, output int rsts,
                           output logic [31:0] data_seen, output logic [1:0] len_seen);
    bit finished = 1'b0;
    low = 0; loads = 0; rsts = 0; data_seen = '0; len_seen = '0;
    for (int it = 0; it < 400; it++) begin
      @(negedge clk);
      bus_if.bus_we = 1'b0;
      rst = 1'b0;
      if (!cs_n) low++;
      if (shf_load) begin
        if (loads == 0) begin
          data_seen = shf_data;
          len_seen  = shf_len;
        end
        loads++;
      end
      if (shf_rst) rsts++;
      if (!cs_n) begin
        case (mode)
          1: if (low == 15) begin
               bus_if.bus_addr = 2'd3; bus_if.bus_wdata = 32'h2; bus_if.bus_we = 1'b1;
             end
          2: begin
               if (low == 5) begin
                 bus_if.bus_addr = 2'd0; bus_if.bus_wdata = 32'h9; bus_if.bus_we = 1'b1;
               end
               if (low == 6) begin
                 bus_if.bus_addr = 2'd1; bus_if.bus_wdata = 32'h55; bus_if.bus_we = 1'b1;
               end
               if (low == 8) check("ovr_shf_data_frozen", shf_data, 32'hA5);
             end
          3: if (low == 6) rst = 1'b1;
          default: ;
        endcase
      end
      if (low > 0 && cs_n) begin
        finished = 1'b1;
        break;
      end
    end
    check("xfer_completed", 32'(finished), 32'd1);
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [31:0] tx;
    logic [31:0] ctrl;
    logic [31:0] rx;
    logic [31:0] exp_rx;
    logic [1:0]  exp_len;
    logic        exp_irq;
  } vec_t;

  vec_t        vecs[4];
  int          low, loads, rsts;
  logic [31:0] dseen;
  logic [1:0]  lseen;

  initial begin
    vecs[0] = '{tx: 32'h0000_00A5, ctrl: 32'h9, rx: 32'hFFFF_FF3C, exp_rx: 32'h0000_003C, exp_len: 2'd0, exp_irq: 1'b1};
    vecs[1] = '{tx: 32'h1234_5678, ctrl: 32'h3, rx: 32'hFFFF_FF3C, exp_rx: 32'h0000_FF3C, exp_len: 2'd1, exp_irq: 1'b0};
    vecs[2] = '{tx: 32'hCAFE_F00D, ctrl: 32'h5, rx: 32'h8765_4321, exp_rx: 32'h0065_4321, exp_len: 2'd2, exp_irq: 1'b0};
    vecs[3] = '{tx: 32'h0F0F_0F0F, ctrl: 32'hF, rx: 32'h8765_4321, exp_rx: 32'h8765_4321, exp_len: 2'd3, exp_irq: 1'b1};

    rst = 1'b1;
    bus_if.bus_addr = 2'd0; bus_if.bus_wdata = '0; bus_if.bus_we = 1'b0; bus_if.bus_re = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_cs_n", 32'(cs_n), 32'd1);
    check("rst_shf_load", 32'(shf_load), 32'd0);
    check("rst_shf_rst", 32'(shf_rst), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_shf_data", shf_data, 32'h0);
    bus_read(2'd3, 32'h0, "rst_status");
    bus_read(2'd2, 32'h0, "rst_rxdata");
    bus_read(2'd0, 32'h0, "rst_ctrl");

    // shf_done outside SHIFT must not start or finish anything
    stray_done = 1'b1;
    @(posedge clk);
    #1 stray_done = 1'b0;
    bus_read(2'd3, 32'h0, "stray_done_status");
    check("stray_done_cs_n", 32'(cs_n), 32'd1);

    for (int v = 0; v < 4; v++) begin
      rx_val = vecs[v].rx;
      bus_write(2'd1, vecs[v].tx);
      bus_write(2'd0, vecs[v].ctrl);
      wait_xfer(0, low, loads, rsts, dseen, lseen);
      check($sformatf("v%0d_cs_low_cycles", v), 32'(low), 32'd15);
      check($sformatf("v%0d_load_cycles", v), 32'(loads), 32'd9);
      check($sformatf("v%0d_rst_pulses", v), 32'(rsts), 32'd1);
      check($sformatf("v%0d_shf_data", v), dseen, vecs[v].tx);
      check($sformatf("v%0d_shf_len", v), 32'(lseen), 32'(vecs[v].exp_len));
      check($sformatf("v%0d_irq", v), 32'(irq), 32'(vecs[v].exp_irq));
      bus_read(2'd2, vecs[v].exp_rx, $sformatf("v%0d_rxdata", v));
      bus_read(2'd3, 32'h2, $sformatf("v%0d_status_done", v));
      bus_write(2'd3, 32'h2);
      check($sformatf("v%0d_irq_after_clear", v), 32'(irq), 32'd0);
      bus_read(2'd3, 32'h0, $sformatf("v%0d_status_cleared", v));
    end
    bus_read(2'd0, 32'hE, "ctrl_readback");
    bus_read(2'd1, 32'h0F0F_0F0F, "txdata_readback");

`ifdef SPI_TIMEOUT_EN
    done_delay = 0;
    bus_write(2'd0, 32'h1);
    wait_xfer(0, low, loads, rsts, dseen, lseen);
    check("tmo_cs_low_cycles", 32'(low), 32'd69);
    check("tmo_load_cycles", 32'(loads), 32'd64);
    bus_read(2'd2, 32'h8765_4321, "tmo_rxdata_kept");
    bus_read(2'd3, 32'hA, "tmo_status");
    bus_write(2'd3, 32'hA);
    bus_read(2'd3, 32'h0, "tmo_status_cleared");
    done_delay = 9;
`endif

    // done W1C lands on the same edge that sets done: set wins
    rx_val = 32'h0000_00C3;
    bus_write(2'd0, 32'h1);
    wait_xfer(1, low, loads, rsts, dseen, lseen);
    check("w1c_cs_low_cycles", 32'(low), 32'd15);
    bus_read(2'd3, 32'h2, "w1c_set_wins");
    bus_read(2'd2, 32'hC3, "w1c_rxdata");
    bus_write(2'd3, 32'h2);

    // start and TXDATA write while busy
    bus_write(2'd1, 32'hA5);
    bus_write(2'd0, 32'h9);
    wait_xfer(2, low, loads, rsts, dseen, lseen);
    check("ovr_cs_low_cycles", 32'(low), 32'd15);
    check("ovr_load_cycles", 32'(loads), 32'd9);
    bus_read(2'd3, 32'h6, "ovr_status");
    bus_read(2'd1, 32'hA5, "ovr_txdata_kept");
    bus_read(2'd2, 32'hC3, "ovr_rxdata");
    bus_write(2'd3, 32'h6);
    bus_read(2'd3, 32'h0, "ovr_status_cleared");

    // reset pulse during SHIFT
    bus_write(2'd0, 32'h1);
    wait_xfer(3, low, loads, rsts, dseen, lseen);
    check("mid_rst_low_cycles", 32'(low), 32'd6);
    check("mid_rst_cs_n", 32'(cs_n), 32'd1);
    check("mid_rst_shf_load", 32'(shf_load), 32'd0);
    bus_read(2'd3, 32'h0, "mid_rst_status");
    bus_read(2'd2, 32'h0, "mid_rst_rxdata");
    repeat (12) @(posedge clk);
    #1;
    bus_read(2'd3, 32'h0, "late_done_ignored");

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/spi_master_ctrl.md
Name: spi_master_ctrl

Overview:
- Bus-facing control stage that sits directly upstream of the SPI serializer/deserializer shift stage in the RISC-V SPI peripheral.
- Exposes four 32-bit registers to the CPU: CTRL, TXDATA, RXDATA and STATUS.
- Sequences one SPI transfer per start command: chip select, shifter reset, shift-enable hold until the shifter reports done, RX capture, CS release and interrupt.
- Drives the shifter's parallel data, length code, load and reset lines; consumes its done flag and parallel receive word.

Parameters:
- DATA_WIDTH, 32, width of the TX/RX words and of the bus data.
- CS_SETUP, 2, clk cycles with CS_n low before shifting starts (range 1..15).
- CS_HOLD, 2, clk cycles with CS_n low after capture, before release (range 1..15).
- TIMEOUT, 64, clk cycles allowed in SHIFT before abort (only with SPI_TIMEOUT_EN).

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  reset, synchronous, active-high.
- bus_addr  in  2  register select: 0 CTRL, 1 TXDATA, 2 RXDATA, 3 STATUS.
- bus_wdata  in  DATA_WIDTH  write data.
- bus_we  in  1  write strobe, one cycle.
- bus_re  in  1  read strobe, one cycle.
- bus_rdata  out  DATA_WIDTH  registered read data.
- irq  out  1  level interrupt = STATUS.done & CTRL.irq_en.
- CS_n  out  1  SPI chip select, active-low.
- shf_rst  out  1  registered one-cycle reset pulse to the shifter.
- shf_load  out  1  shift enable to the shifter.
- shf_data  out  DATA_WIDTH  TXDATA value to be sent.
- shf_len  out  2  SPI length code: 00 = 8 bits, 01 = 16, 10 = 24, 11 = 32.
- shf_done  in  1  shifter transfer-complete flag.
- shf_rx  in  DATA_WIDTH  shifter parallel receive word.

Behaviour:
Reset values: every output 0 except CS_n = 1; all registers 0; state IDLE.

Register map:
- CTRL: bit0 start (write-1 pulse, reads 0), bits2:1 len, bit3 irq_en.
- TXDATA: read/write.
- RXDATA: read-only.
- STATUS: bit0 busy (RO), bit1 done (sticky, write-1-to-clear), bit2 overrun (sticky, W1C), bit3 timeout (sticky, W1C; reads 0 without the macro).

Bus timing and write rules:
- bus_rdata is valid one cycle after bus_re and holds until the next read.
- A read of an unused bit returns 0.
- Writes to CTRL.len or TXDATA while busy are ignored; shf_data and shf_len stay frozen for the whole transfer.
- start while busy is ignored and sets overrun.

State machine:
- IDLE: CS_n = 1, shf_load = 0. A write with start = 1 moves to RST and clears STATUS.done.
- RST: 1 cycle, shf_rst = 1, CS_n = 0.
- SETUP: CS_SETUP cycles, CS_n = 0, shf_load = 0. The shifter loads shf_data during this state.
- SHIFT: shf_load = 1 until shf_done is sampled high.
- CAPTURE: 1 cycle, shf_load = 0. RXDATA <= shf_rx masked to the lower N bits (N = 8/16/24/32 per len); upper bits are 0.
- HOLD: CS_HOLD cycles, CS_n = 0.
- Then IDLE, CS_n = 1, STATUS.done = 1 in the same cycle.
- busy = 1 in every state except IDLE.

Boundary cases:
- shf_done is ignored outside SHIFT.
- A STATUS.done W1C in the same cycle as done is set: set wins.
- rst mid-transfer returns to IDLE next edge; CS_n = 1 and RXDATA = 0.

Optional Feature:
SPI_TIMEOUT_EN
- Defined: an 8-bit counter runs while in SHIFT. When it reaches TIMEOUT, the block goes to HOLD without capture: RXDATA is unchanged, STATUS.timeout = 1 and STATUS.done = 1.
- Undefined: no counter, and SHIFT waits indefinitely for shf_done.

Test Plan:
- Reset: after rst, expect CS_n = 1, shf_load = 0, irq = 0, and read of STATUS = 0x0.
- 8-bit transfer:
  - Stimulus: TXDATA = 0xA5, CTRL = 0x9 (start, len 00, irq_en), shifter model asserts shf_done 9 cycles after shf_load rises with shf_rx = 0xFFFF_FF3C.
  - Response: CS_n low for exactly 1 + CS_SETUP + 9 + 1 + CS_HOLD cycles; RXDATA = 0x3C; STATUS = 0x2; irq = 1.
- Done clear: write STATUS = 0x2 after the above -> STATUS reads 0x0 and irq = 0 on the following cycle.
- Overrun: start during SHIFT -> transfer unaffected, STATUS.overrun = 1, and a TXDATA write of 0x55 is ignored (shf_data still 0xA5).
- Mid-transfer reset: rst asserted in SHIFT for 1 cycle -> next edge CS_n = 1, shf_load = 0, busy = 0.
- Timeout (SPI_TIMEOUT_EN defined):
  - Stimulus: shf_done held low.
  - Response: after 64 SHIFT cycles the block enters HOLD; STATUS = 0xA; RXDATA keeps its previous value.
